// File: rtl/apb_master_arb.sv
// apb_master_arb: two-port round-robin APB master with optional PREADY timeout
module apb_master_arb #(
  parameter int unsigned     TO_W     = 8,
  parameter logic [TO_W-1:0] TIMEOUT  = TO_W'(200),
  parameter logic [31:0]     ERR_DATA = 32'hDEADBEEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic last_grant, grant, elig0, elig1, pick, expire;
  always_comb begin
    elig0 = m0_req & ~m0_done;
    elig1 = m1_req & ~m1_done;
    pick  = (elig0 & elig1) ? ~last_grant : elig1;
  end
`ifdef APB_TIMEOUT_EN
  logic [TO_W-1:0] wait_cnt;
  always_comb expire = ~PREADY & (wait_cnt == TIMEOUT);
`else
  always_comb expire = 1'b0;
`endif
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rdata      <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      err        <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: if (elig0 | elig1) begin
          grant  <= pick;
          PSEL   <= 1'b1;
          PWRITE <= pick ? m1_write : m0_write;
          PADDR  <= pick ? m1_addr  : m0_addr;
          PWDATA <= pick ? m1_wdata : m0_wdata;
          state  <= SETUP;
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: if (PREADY | expire) begin
          if (expire) begin
            rdata <= ERR_DATA;
            err   <= 1'b1;
          end else if (!PWRITE) rdata <= PRDATA;
          m0_done    <= ~grant;
          m1_done    <= grant;
          PSEL       <= 1'b0;
          PENABLE    <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else wait_cnt <= wait_cnt + 1'b1;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: vector, arbitration, random, timeout and reset checks against a transaction model
module tb_apb_master_arb;
  localparam logic [31:0] SALT = 32'h12345668;
  localparam int          TO   = 5;

  typedef struct { bit wr; logic [31:0] ad; logic [31:0] wd; } req_t;
  typedef struct { int port; bit wr; logic [31:0] ad; logic [31:0] wd; int stall; int lat; logic [31:0] rd; } vec_t;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        req [2] = '{1'b0, 1'b0};
  logic        wr  [2] = '{1'b0, 1'b0};
  logic [31:0] ad  [2] = '{32'd0, 32'd0};
  logic [31:0] wd  [2] = '{32'd0, 32'd0};
  logic        m0_done, m1_done, err, PSEL, PENABLE, PWRITE;
  logic [31:0] rdata, PADDR, PWDATA, PRDATA;
  logic        PREADY = 1'b0;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  apb_master_arb #(.TIMEOUT(8'd5)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .m0_req(req[0]), .m0_write(wr[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]), .m0_done(m0_done),
    .m1_req(req[1]), .m1_write(wr[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]), .m1_done(m1_done),
    .rdata(rdata), .err(err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  int acc = 0, cur_stall = 0, stall_fix = 0;
  assign PRDATA = PREADY ? (PADDR ^ SALT) : 32'h0BAD0BAD;
  always @(posedge PCLK) begin
    #1;
    if (PSEL && PENABLE) begin
      if (acc == 0) cur_stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 4));
      PREADY = (acc >= cur_stall);
      acc++;
    end else begin
      PREADY = 1'b0;
      acc = 0;
    end
  end

  req_t q0[$], q1[$];
  bit   seen[2] = '{1'b0, 1'b0};
  int   rise[2] = '{0, 0};
  bit   gaps = 1'b0;
  always @(posedge PCLK) begin
    req_t r;
    logic dn;
    int   n;
    #1;
    for (int p = 0; p < 2; p++) begin
      dn = (p == 1) ? m1_done : m0_done;
      n  = (p == 1) ? q1.size() : q0.size();
      if (!PRESETn) begin
        req[p] = 1'b0;
        seen[p] = 1'b0;
      end else if (req[p]) begin
        if (dn) seen[p] = 1'b1;
        else if (seen[p]) begin
          req[p] = 1'b0;
          seen[p] = 1'b0;
          wr[p] = 1'($urandom);
          ad[p] = $urandom;
          wd[p] = $urandom;
          if (p == 1) void'(q1.pop_front()); else void'(q0.pop_front());
        end
      end else if (n > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
        r = (p == 1) ? q1[0] : q0[0];
        req[p] = 1'b1;
        wr[p] = r.wr;
        ad[p] = r.ad;
        wd[p] = r.wd;
        rise[p] = cyc;
      end
    end
    if (!PRESETn) begin
      q0.delete();
      q1.delete();
    end
  end

  int          g = -1, t0 = 0, stalls = 0, g_cnt = 0;
  int          dn_cnt[2] = '{0, 0};
  int          lat[2] = '{0, 0};
  int          dlog[$];
  bit          lg = 1'b1;
  bit          md[2] = '{1'b0, 1'b0};
  logic [31:0] m_rd = '0, last_rd = '0, cur_ad = '0, cur_wd = '0;
  logic        cur_wr = 1'b0, last_err = 1'b0, p_rdy = 1'b0;
  logic        p_req[2] = '{1'b0, 1'b0};
  logic        p_wr[2] = '{1'b0, 1'b0};
  logic [31:0] p_ad[2] = '{32'd0, 32'd0};
  logic [31:0] p_wd[2] = '{32'd0, 32'd0};

  always @(negedge PCLK) begin
    bit nd0, nd1, e0, e1, ne, fin;
    nd0 = 1'b0; nd1 = 1'b0; ne = 1'b0; fin = 1'b0;
    if (!PRESETn) begin
      chk("reset_ctl", {26'd0, PSEL, PENABLE, PWRITE, m0_done, m1_done, err}, 32'd0);
      chk("reset_paddr", PADDR, 32'd0);
      chk("reset_pwdata", PWDATA, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      g = -1;
      lg = 1'b1;
      m_rd = '0;
    end else begin
      if (g >= 0) begin
        if (cyc > t0 + 1 && p_rdy) begin
          if (!cur_wr) m_rd = cur_ad ^ SALT;
          fin = 1'b1;
        end else if (cyc > t0 + 1) begin
`ifdef APB_TIMEOUT_EN
          if (stalls == TO) begin
            m_rd = 32'hDEADBEEF;
            ne = 1'b1;
            fin = 1'b1;
          end
`endif
          stalls++;
        end
        if (fin) begin
          nd0 = (g == 0);
          nd1 = (g == 1);
          lg = (g == 1);
          g = -1;
        end
      end else begin
        e0 = p_req[0] && !md[0];
        e1 = p_req[1] && !md[1];
        if (e0 || e1) begin
          g = (e0 && e1) ? (lg ? 0 : 1) : (e1 ? 1 : 0);
          t0 = cyc;
          stalls = 0;
          cur_wr = p_wr[g];
          cur_ad = p_ad[g];
          cur_wd = p_wd[g];
        end
      end
      chk("psel", PSEL, g >= 0);
      chk("penable", PENABLE, g >= 0 && cyc > t0);
      if (g >= 0) begin
        chk("pwrite", PWRITE, cur_wr);
        chk("paddr", PADDR, cur_ad);
        chk("pwdata", PWDATA, cur_wd);
      end
      chk("m0_done", m0_done, nd0);
      chk("m1_done", m1_done, nd1);
      chk("err", err, ne);
      chk("rdata", rdata, m_rd);
    end
    if (m0_done) begin dn_cnt[0]++; dlog.push_back(0); lat[0] = cyc - rise[0]; last_err = err; last_rd = rdata; end
    if (m1_done) begin dn_cnt[1]++; dlog.push_back(1); lat[1] = cyc - rise[1]; last_err = err; last_rd = rdata; end
    if (PSEL && !PENABLE) g_cnt++;
    md[0] = nd0;
    md[1] = nd1;
    p_rdy = PREADY;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = req[p];
      p_wr[p] = wr[p];
      p_ad[p] = ad[p];
      p_wd[p] = wd[p];
    end
  end

  task automatic push(input int p, input req_t r);
    if (p == 1) q1.push_back(r); else q0.push_back(r);
  endtask

  task automatic wait_dn(input int p, input int target, input int budget);
    int k = 0;
    while (dn_cnt[p] < target && k < budget) begin
      @(negedge PCLK); #1;
      k++;
    end
    chk($sformatf("wait_done_p%0d", p), dn_cnt[p], target);
  endtask

  task automatic do_reset();
    @(negedge PCLK); #2 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    #3 PRESETn = 1'b1;
    @(negedge PCLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    req_t r;
    int   base, b0, b1, k;
    tbl[0] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 0, 3, 32'h1234_5678};
    tbl[1] = '{1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4, 7, 32'h1234_5678};
    tbl[2] = '{0, 1'b1, 32'h0001_0020, 32'h0000_0000, 1, 4, 32'h1234_5678};
    tbl[3] = '{1, 1'b0, 32'h00FF_0000, 32'h1111_1111, 2, 5, 32'h12CB_5668};
    tbl[4] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 0, 3, 32'hEDCB_A994};
    tbl[5] = '{1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 3, 6, 32'h1234_5668};

    repeat (3) @(negedge PCLK);
    #3 PRESETn = 1'b1;
    @(negedge PCLK); #1;

    for (int i = 0; i < 6; i++) begin
      stall_fix = tbl[i].stall;
      base = dn_cnt[tbl[i].port];
      r.wr = tbl[i].wr; r.ad = tbl[i].ad; r.wd = tbl[i].wd;
      push(tbl[i].port, r);
      wait_dn(tbl[i].port, base + 1, 50);
      chk($sformatf("vec%0d_latency", i), lat[tbl[i].port], tbl[i].lat);
      chk($sformatf("vec%0d_rdata", i), last_rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), last_err, 1'b0);
      repeat (2) @(negedge PCLK);
      #1;
    end

    do_reset();
    stall_fix = 0;
    dlog.delete();
    b0 = dn_cnt[0]; b1 = dn_cnt[1]; base = g_cnt;
    for (int i = 0; i < 4; i++) begin
      r.wr = 1'(i); r.ad = 32'h0010_0000 + 32'(i * 4); r.wd = $urandom;
      push(0, r);
      r.wr = 1'(~i); r.ad = 32'h0020_0000 + 32'(i * 4); r.wd = $urandom;
      push(1, r);
    end
    wait_dn(0, b0 + 4, 100);
    wait_dn(1, b1 + 4, 100);
    repeat (6) @(negedge PCLK);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), (i < dlog.size()) ? dlog[i] : -1, i % 2);
    chk("rr_grant_count", g_cnt - base, 8);

    gaps = 1'b1;
    stall_fix = -1;
    b0 = dn_cnt[0]; b1 = dn_cnt[1]; base = g_cnt;
    for (int i = 0; i < 40; i++) begin
      r.wr = 1'($urandom); r.ad = $urandom; r.wd = $urandom;
      push(0, r);
      r.wr = 1'($urandom); r.ad = $urandom; r.wd = $urandom;
      push(1, r);
    end
    wait_dn(0, b0 + 40, 4000);
    wait_dn(1, b1 + 40, 4000);
    repeat (6) @(negedge PCLK);
    #1;
    chk("rand_grant_count", g_cnt - base, 80);
    chk("rand_queues_empty", q0.size() + q1.size(), 0);
    gaps = 1'b0;

`ifdef APB_TIMEOUT_EN
    stall_fix = 1000;
    base = dn_cnt[0];
    r.wr = 1'b0; r.ad = 32'h0000_0200; r.wd = 32'h0;
    push(0, r);
    wait_dn(0, base + 1, 50);
    chk("to_latency", lat[0], 3 + TO);
    chk("to_err", last_err, 1'b1);
    chk("to_rdata", last_rd, 32'hDEAD_BEEF);
    repeat (2) @(negedge PCLK);
    #1;
    stall_fix = 0;
    base = dn_cnt[1];
    r.wr = 1'b1; r.ad = 32'h0000_0300; r.wd = 32'h55AA_55AA;
    push(1, r);
    wait_dn(1, base + 1, 50);
    chk("after_to_latency", lat[1], 3);
    chk("after_to_err", last_err, 1'b0);
    chk("after_to_rdata", last_rd, 32'hDEAD_BEEF);
    repeat (2) @(negedge PCLK);
    #1;
`endif

    stall_fix = 20;
    base = dn_cnt[0];
    r.wr = 1'b0; r.ad = 32'h0003_0040; r.wd = 32'h0;
    push(0, r);
    k = 0;
    while (!(PSEL && PENABLE) && k < 20) begin
      @(negedge PCLK); #1;
      k++;
    end
    chk("rst_reached_access", PSEL && PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_psel_penable", {PSEL, PENABLE}, 2'b00);
    repeat (2) @(negedge PCLK);
    #3 PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    #1;
    chk("abandoned_no_done", dn_cnt[0], base);
    stall_fix = 0;
    r.wr = 1'b0; r.ad = 32'h0000_0100; r.wd = 32'h0;
    push(0, r);
    wait_dn(0, base + 1, 50);
    chk("post_rst_latency", lat[0], 3);
    chk("post_rst_rdata", last_rd, 32'h1234_5768);
    repeat (3) @(negedge PCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
